branch_predictor: RTL and testbench
===================================

# branch_predictor

Direct-mapped branch target buffer with 2-bit saturating direction counters. It is looked up by the fetch stage with the fetch PC, and it is trained by the execute stage with the resolved target and outcome computed there. It is the consumer of the execute-stage branch target (PCE + immediate): it stores that target, replays it at fetch, and flags a mispredict when the resolved outcome disagrees with the prediction carried down the pipe.

## Interface
- DATA_WIDTH, 32, address/data width
- ENTRIES, 16, number of BTB entries; power of two, minimum 2; IDX = log2(ENTRIES)

- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- PCF_i  in  DATA_WIDTH  fetch-stage PC for lookup
- PredTakenF_o  out  1  fetch prediction: taken
- PredTargetF_o  out  DATA_WIDTH  predicted next PC
- UpdateE_i  in  1  a branch or jump resolved in execute this cycle
- PCE_i  in  DATA_WIDTH  execute-stage PC of the resolving instruction
- PCTargetE_i  in  DATA_WIDTH  resolved target (PCE + immediate)
- TakenE_i  in  1  resolved outcome
- PredTakenE_i  in  1  prediction carried with the instruction from fetch
- PredTargetE_i  in  DATA_WIDTH  predicted target carried from fetch
- MispredictE_o  out  1  redirect required this cycle
- RedirectPCE_o  out  DATA_WIDTH  correct next PC on mispredict
- MispredictCount_o  out  32  running mispredict count

## Operation
- Entry fields: valid, tag = PC[DATA_WIDTH-1:IDX+2], target[DATA_WIDTH-1:0], ctr[1:0]. Index = PC[IDX+1:2]. PC[1:0] are ignored everywhere.
- Lookup is combinational from PCF_i:
  - hit = valid & tag match.
  - PredTakenF_o = hit & ctr[1].
  - PredTargetF_o = the stored target when PredTakenF_o is high, otherwise PCF_i + 4.
- Mispredict resolution is combinational and gated by UpdateE_i:
  - MispredictE_o = UpdateE_i & ((TakenE_i != PredTakenE_i) | (TakenE_i & PredTakenE_i & PredTargetE_i != PCTargetE_i)).
  - RedirectPCE_o = TakenE_i ? PCTargetE_i : PCE_i + 4. It is valid whenever UpdateE_i is high.
- Training happens on the clock edge with UpdateE_i high, at the index of PCE_i:
  - Hit, taken: ctr saturating +1 (max 11); target ← PCTargetE_i.
  - Hit, not taken: ctr saturating −1 (min 00); target unchanged.
  - Miss, taken: allocate. valid ← 1, tag ← PCE_i tag, target ← PCTargetE_i, ctr ← 10 (weakly taken). Any previous entry at that index is overwritten.
  - Miss, not taken: no change.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- MispredictCount_o increments by 1 on every edge where MispredictE_o is high. It wraps from 0xFFFF_FFFF to 0.
- With UpdateE_i low, no state changes.

## Timing
- Lookup has zero-cycle latency (combinational in the same cycle).
- Training is visible to lookups from the cycle after the update edge.
- Simultaneous lookup and update at the same index: the lookup returns pre-update contents. There is no write-to-read bypass.
- Reset (asynchronous, any time, including mid-update):
  - All valid bits ← 0, all ctr ← 01, MispredictCount_o ← 0.
  - Targets and tags need not be reset.
  - During and after reset: PredTakenF_o = 0 and PredTargetF_o = PCF_i + 4. MispredictE_o depends only on inputs.
- Stall and flush are the pipeline's responsibility. A flushed instruction must arrive with UpdateE_i low.
- All adds are DATA_WIDTH-bit modulo; PC + 4 wraps silently.

## Structure
- Shared package `branch_pkg`:
  - `btb_entry_t` struct (valid, tag, target, ctr).
  - Counter constants CTR_SNT/CTR_WNT/CTR_WT/CTR_ST.
  - Pure function `ctr_next(ctr, taken)` for the saturating update.
- No sub-module. The entry array is a flop array inside the block, because the valid/ctr reset must be asynchronous.

## Test plan
- **Reset, then lookup.** Deassert rst_ni; PCF_i = 0x0000_0100 → PredTakenF_o = 0, PredTargetF_o = 0x0000_0104, MispredictCount_o = 0.
- **Allocate on taken miss.** UpdateE_i = 1, PCE_i = 0x100, PCTargetE_i = 0x80, TakenE_i = 1, PredTakenE_i = 0 → MispredictE_o = 1, RedirectPCE_o = 0x80. Next cycle, PCF_i = 0x100 → PredTakenF_o = 1, PredTargetF_o = 0x80; count = 1.
- **Hysteresis.** From ctr = 10: one not-taken update (predicted taken) → MispredictE_o = 1, RedirectPCE_o = 0x104, ctr = 01, lookup now predicts not-taken. Two taken updates → ctr = 11. One not-taken → ctr = 10, still predicts taken.
- **Alias eviction and target change.**
  - PCE_i = 0x140 (same index as 0x100 with ENTRIES = 16, different tag), taken to 0x200 → lookup of 0x100 misses and predicts 0x104; lookup of 0x140 predicts 0x200.
  - Taken update of 0x140 to 0x300 with PredTargetE_i = 0x200 → MispredictE_o = 1; target becomes 0x300.
- **Same-cycle read/write and not-taken miss.**
  - Update of 0x100 on the same edge as lookup of 0x100 → the lookup shows old contents until the next cycle.
  - A not-taken update of an unmapped PC changes nothing.
- **Counter wrap and async reset.**
  - Force 2^32 mispredicts (or preload via hierarchy) → MispredictCount_o wraps to 0.
  - Assert rst_ni between edges during an update → valid bits clear immediately and the update is discarded.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types, counter encodings and the saturating-counter helper for the
// branch target buffer.
package branch_pkg;

    localparam int BP_DATA_WIDTH = 32;
    localparam int BP_ENTRIES    = 16;
    localparam int BP_IDX        = $clog2(BP_ENTRIES);
    localparam int BP_TAG_W      = BP_DATA_WIDTH - BP_IDX - 2;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic                     valid;
        logic [BP_TAG_W-1:0]      tag;
        logic [BP_DATA_WIDTH-1:0] target;
        logic [1:0]               ctr;
    } btb_entry_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: combinational lookup at
// fetch, training and mispredict detection from the execute stage.
module branch_predictor
    import branch_pkg::*;
#(
    parameter int DATA_WIDTH = BP_DATA_WIDTH,
    parameter int ENTRIES    = BP_ENTRIES
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] PCF_i,
    output logic                  PredTakenF_o,
    output logic [DATA_WIDTH-1:0] PredTargetF_o,
    input  logic                  UpdateE_i,
    input  logic [DATA_WIDTH-1:0] PCE_i,
    input  logic [DATA_WIDTH-1:0] PCTargetE_i,
    input  logic                  TakenE_i,
    input  logic                  PredTakenE_i,
    input  logic [DATA_WIDTH-1:0] PredTargetE_i,
    output logic                  MispredictE_o,
    output logic [DATA_WIDTH-1:0] RedirectPCE_o,
    output logic [31:0]           MispredictCount_o
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX - 2;

    // The entry struct is sized by the package, so the geometry must match it.
    if (DATA_WIDTH != BP_DATA_WIDTH || ENTRIES != BP_ENTRIES) begin : g_bad_cfg
        $error("branch_predictor geometry must match branch_pkg");
    end

    logic                  valid_q  [ENTRIES];
    logic [1:0]            ctr_q    [ENTRIES];
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [DATA_WIDTH-1:0] target_q [ENTRIES];
    logic [31:0]           mispredict_count_q;

    logic [IDX-1:0] f_idx;
    logic [IDX-1:0] e_idx;
    btb_entry_t     f_entry;
    btb_entry_t     e_entry;
    logic           f_hit;
    logic           e_hit;

    assign f_idx = PCF_i[IDX+1:2];
    assign e_idx = PCE_i[IDX+1:2];

    always_comb begin
        f_entry.valid  = valid_q[f_idx];
        f_entry.tag    = tag_q[f_idx];
        f_entry.target = target_q[f_idx];
        f_entry.ctr    = ctr_q[f_idx];
        e_entry.valid  = valid_q[e_idx];
        e_entry.tag    = tag_q[e_idx];
        e_entry.target = target_q[e_idx];
        e_entry.ctr    = ctr_q[e_idx];
    end

    assign f_hit = f_entry.valid && (f_entry.tag == PCF_i[DATA_WIDTH-1:IDX+2]);
    assign e_hit = e_entry.valid && (e_entry.tag == PCE_i[DATA_WIDTH-1:IDX+2]);

    assign PredTakenF_o  = f_hit & f_entry.ctr[1];
    assign PredTargetF_o = PredTakenF_o ? f_entry.target : PCF_i + DATA_WIDTH'(4);

    assign MispredictE_o = UpdateE_i &
                           ((TakenE_i != PredTakenE_i) |
                            (TakenE_i & PredTakenE_i & (PredTargetE_i != PCTargetE_i)));
    assign RedirectPCE_o = TakenE_i ? PCTargetE_i : PCE_i + DATA_WIDTH'(4);

    // Valid bits and counters carry the asynchronous reset; a not-taken miss
    // leaves the entry untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (UpdateE_i) begin
            if (e_hit) begin
                ctr_q[e_idx] <= ctr_next(e_entry.ctr, TakenE_i);
            end else if (TakenE_i) begin
                valid_q[e_idx] <= 1'b1;
                ctr_q[e_idx]   <= CTR_WT;
            end
        end
    end

    // Any taken resolution either refreshes a hit's target or allocates, so
    // tag and target are written together without a reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni && UpdateE_i && TakenE_i) begin
            tag_q[e_idx]    <= PCE_i[DATA_WIDTH-1:IDX+2];
            target_q[e_idx] <= PCTargetE_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mispredict_count_q <= 32'd0;
        end else if (MispredictE_o) begin
            mispredict_count_q <= mispredict_count_q + 32'd1;
        end
    end

    assign MispredictCount_o = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized checks of branch_predictor against a small
// table-of-branches model.
module tb_branch_predictor;

    localparam int          ENTRIES = 16;
    localparam logic [31:0] ENT_U   = 32'd16;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] PCF_i;
    logic        PredTakenF_o;
    logic [31:0] PredTargetF_o;
    logic        UpdateE_i;
    logic [31:0] PCE_i;
    logic [31:0] PCTargetE_i;
    logic        TakenE_i;
    logic        PredTakenE_i;
    logic [31:0] PredTargetE_i;
    logic        MispredictE_o;
    logic [31:0] RedirectPCE_o;
    logic [31:0] MispredictCount_o;

    always #5 clk_i = ~clk_i;

    branch_predictor #(.DATA_WIDTH(32), .ENTRIES(16)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .PCF_i             (PCF_i),
        .PredTakenF_o      (PredTakenF_o),
        .PredTargetF_o     (PredTargetF_o),
        .UpdateE_i         (UpdateE_i),
        .PCE_i             (PCE_i),
        .PCTargetE_i       (PCTargetE_i),
        .TakenE_i          (TakenE_i),
        .PredTakenE_i      (PredTakenE_i),
        .PredTargetE_i     (PredTargetE_i),
        .MispredictE_o     (MispredictE_o),
        .RedirectPCE_o     (RedirectPCE_o),
        .MispredictCount_o (MispredictCount_o)
    );

    int checks = 0;
    int errors = 0;

    // Model: one remembered branch per slot, with a confidence level 0..3.
    bit          mValid    [ENTRIES];
    logic [31:0] mKey      [ENTRIES];
    logic [31:0] mTarget   [ENTRIES];
    int          mStrength [ENTRIES];
    int unsigned mCount;

    function automatic int slotOf(input logic [31:0] pc);
        return int'((pc >> 2) % ENT_U);
    endfunction

    function automatic logic [31:0] keyOf(input logic [31:0] pc);
        return (pc >> 2) / ENT_U;
    endfunction

    function automatic bit modelHit(input logic [31:0] pc);
        return mValid[slotOf(pc)] && (mKey[slotOf(pc)] == keyOf(pc));
    endfunction

    function automatic bit modelTaken(input logic [31:0] pc);
        return modelHit(pc) && (mStrength[slotOf(pc)] >= 2);
    endfunction

    function automatic bit modelMispredict();
        if (!UpdateE_i) return 1'b0;
        if (TakenE_i != PredTakenE_i) return 1'b1;
        return TakenE_i && (PredTargetE_i != PCTargetE_i);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < ENTRIES; i++) begin
            mValid[i]    = 1'b0;
            mStrength[i] = 1;
        end
        mCount = 0;
    endtask

    task automatic modelTrain();
        int s;
        s = slotOf(PCE_i);
        if (!UpdateE_i) return;
        if (modelHit(PCE_i)) begin
            if (TakenE_i) begin
                mStrength[s] = (mStrength[s] == 3) ? 3 : mStrength[s] + 1;
                mTarget[s]   = PCTargetE_i;
            end else begin
                mStrength[s] = (mStrength[s] == 0) ? 0 : mStrength[s] - 1;
            end
        end else if (TakenE_i) begin
            mValid[s]    = 1'b1;
            mKey[s]      = keyOf(PCE_i);
            mTarget[s]   = PCTargetE_i;
            mStrength[s] = 2;
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] pcf, input logic upd, input logic [31:0] pce,
                                 input logic [31:0] tgt, input logic tk, input logic ptk,
                                 input logic [31:0] ptgt);
        PCF_i         = pcf;
        UpdateE_i     = upd;
        PCE_i         = pce;
        PCTargetE_i   = tgt;
        TakenE_i      = tk;
        PredTakenE_i  = ptk;
        PredTargetE_i = ptgt;
    endtask

    task automatic checkOutput(input string tag);
        bit          expTaken;
        logic [31:0] expTarget;
        expTaken  = modelTaken(PCF_i);
        expTarget = expTaken ? mTarget[slotOf(PCF_i)] : PCF_i + 32'd4;
        checkVal({tag, ":predTaken"}, {31'd0, PredTakenF_o}, {31'd0, expTaken});
        checkVal({tag, ":predTarget"}, PredTargetF_o, expTarget);
        checkVal({tag, ":mispredict"}, {31'd0, MispredictE_o}, {31'd0, modelMispredict()});
        if (UpdateE_i)
            checkVal({tag, ":redirect"}, RedirectPCE_o, TakenE_i ? PCTargetE_i : PCE_i + 32'd4);
        checkVal({tag, ":count"}, MispredictCount_o, mCount);
    endtask

    task automatic tick();
        bit mis;
        mis = modelMispredict();
        @(posedge clk_i);
        if (rst_ni) begin
            modelTrain();
            if (mis) mCount++;
        end
        #1;
    endtask

    task automatic step(input string tag, input logic [31:0] pcf, input logic upd,
                        input logic [31:0] pce, input logic [31:0] tgt, input logic tk,
                        input logic ptk, input logic [31:0] ptgt);
        applyStimulus(pcf, upd, pce, tgt, tk, ptk, ptgt);
        #3;
        checkOutput(tag);
        tick();
    endtask

    initial begin
        logic [31:0] rpc;
        logic [31:0] rpcf;
        logic [31:0] rtgt;
        logic        rtk;

        $display("[TB] start");
        modelReset();
        rst_ni = 1'b0;
        applyStimulus(32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        #3;
        checkOutput("in_reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        step("post_reset", 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        step("alloc", 32'h200, 1'b1, 32'h100, 32'h80, 1'b1, 1'b0, 32'h104);
        step("alloc_look", 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        step("hyst_nt", 32'h100, 1'b1, 32'h100, 32'h80, 1'b0, 1'b1, 32'h80);
        step("hyst_look1", 32'h100, 1'b1, 32'h100, 32'h80, 1'b1, 1'b0, 32'h104);
        step("hyst_t2", 32'h100, 1'b1, 32'h100, 32'h80, 1'b1, 1'b1, 32'h80);
        step("hyst_nt2", 32'h100, 1'b1, 32'h100, 32'h80, 1'b0, 1'b1, 32'h80);
        step("hyst_look2", 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        step("alias_alloc", 32'h300, 1'b1, 32'h140, 32'h200, 1'b1, 1'b0, 32'h144);
        step("alias_old", 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        step("alias_new", 32'h140, 1'b1, 32'h140, 32'h300, 1'b1, 1'b1, 32'h200);
        step("alias_tgt", 32'h140, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        step("same_cycle", 32'h100, 1'b1, 32'h100, 32'h180, 1'b1, 1'b0, 32'h104);
        step("same_after", 32'h100, 1'b1, 32'h3c0, 32'h40, 1'b0, 1'b0, 32'h0);
        step("nt_miss", 32'h3c0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        step("pc_wrap", 32'hffff_fffc, 1'b1, 32'hffff_fffc, 32'h10, 1'b0, 1'b0, 32'h0);

        // Reset lands between edges while an allocating update is presented.
        applyStimulus(32'h100, 1'b1, 32'h240, 32'h80, 1'b1, 1'b0, 32'h244);
        #1;
        rst_ni = 1'b0;
        modelReset();
        #1;
        checkOutput("async_rst");
        tick();
        rst_ni = 1'b1;
        step("rst_discard", 32'h240, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        for (int n = 0; n < 400; n++) begin
            rpc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            rpcf = ($urandom_range(0, 3) == 0) ? rpc :
                   (($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
            rtgt = {$urandom_range(0, 7), 2'b00};
            rtk  = 1'($urandom_range(0, 1));
            step("rand", rpcf, 1'($urandom_range(0, 3) != 0), rpc, rtgt, rtk,
                 ($urandom_range(0, 1) != 0) ? 1'(modelTaken(rpc)) : 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) != 0) ? rtgt : {$urandom_range(0, 7), 2'b00});
        end

        // Preload the counter just below the wrap point.
        applyStimulus(32'h100, 1'b1, 32'h200, 32'h10, 1'b1, 1'b0, 32'h204);
        force dut.mispredict_count_q = 32'hffff_ffff;
        #1;
        release dut.mispredict_count_q;
        mCount = 32'hffff_ffff;
        #1;
        checkOutput("wrap_pre");
        tick();
        step("wrap_post", 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
